// File: rtl/clock_display_scan_if.sv
// Signal bundle between the clock/calendar datapath and the 7-segment scan driver.
// Inputs are plain levels; the scanner samples them once per frame.
interface clock_display_scan_if;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [3:0] month;
  logic [4:0] day;
  logic [2:0] status;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] digit_en;
  logic       frame_done;
  logic [1:0] dbg_state;

  modport master (
    output hour, minute, second, month, day, status,
    input  seg, dp, digit_en, frame_done, dbg_state
  );

  modport slave (
    input  hour, minute, second, month, day, status,
    output seg, dp, digit_en, frame_done, dbg_state
  );
endinterface

// File: rtl/clock_display_scan.sv
// 4-digit multiplexed 7-segment scanner with per-frame snapshot, serial BCD
// conversion by repeated subtraction, blanking dead-time and edit-field blinking.
module clock_display_scan #(
  parameter int SCAN_DIV     = 64,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                 clock,
  input  logic                 reset,
  clock_display_scan_if.slave  bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_CONV  = 2'd1,
    S_DRIVE = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      r_tens, w_tens_nxt;
  logic [5:0]      r_rem, w_rem_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic [FW-1:0]   r_frame_cnt;
  logic            r_hidden;

  logic [4:0]      r_hour;
  logic [5:0]      r_minute;
  logic            r_second0;
  logic [3:0]      r_month;
  logic [4:0]      r_day;
  logic [2:0]      r_status;

  logic [2:0]      w_status_live;
  logic [2:0]      w_cur_status;
  logic [4:0]      w_cur_hour;
  logic [5:0]      w_cur_minute;
  logic [3:0]      w_cur_month;
  logic [4:0]      w_cur_day;
  logic            w_cal;
  logic [5:0]      w_v;
  logic [3:0]      w_digit;
  logic            w_hide_pair;
  logic            w_snap;

  logic [6:0]      w_seg;
  logic            w_dp;
  logic [3:0]      w_digit_en;

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'h3F;
      4'd1:    font = 7'h06;
      4'd2:    font = 7'h5B;
      4'd3:    font = 7'h4F;
      4'd4:    font = 7'h66;
      4'd5:    font = 7'h6D;
      4'd6:    font = 7'h7D;
      4'd7:    font = 7'h07;
      4'd8:    font = 7'h7F;
      4'd9:    font = 7'h6F;
      default: font = 7'h00;
    endcase
  endfunction

  // Digit 0's LOAD is the snapshot cycle, so it must read the live inputs directly.
  assign w_snap        = (r_state == S_LOAD) && (r_idx == 2'd0);
  assign w_status_live = (bus.status > 3'd4) ? 3'd0 : bus.status;
  assign w_cur_status  = (r_idx == 2'd0) ? w_status_live : r_status;
  assign w_cur_hour    = (r_idx == 2'd0) ? bus.hour      : r_hour;
  assign w_cur_minute  = (r_idx == 2'd0) ? bus.minute    : r_minute;
  assign w_cur_month   = (r_idx == 2'd0) ? bus.month     : r_month;
  assign w_cur_day     = (r_idx == 2'd0) ? bus.day       : r_day;
  assign w_cal         = (w_cur_status >= 3'd3);

  always_comb begin
    w_v = 6'd0;
    if (!r_idx[1]) begin
      w_v = w_cal ? {2'b00, w_cur_month} : {1'b0, w_cur_hour};
    end else begin
      w_v = w_cal ? {1'b0, w_cur_day} : w_cur_minute;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_tens_nxt       = r_tens;
    w_rem_nxt        = r_rem;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_tens_nxt  = 3'd0;
        w_rem_nxt   = w_v;
        w_state_nxt = S_CONV;
      end
      S_CONV: begin
        if (r_rem >= 6'd10) begin
          w_rem_nxt  = r_rem - 6'd10;
          w_tens_nxt = r_tens + 3'd1;
        end else begin
          w_state_nxt = S_DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == CW'(SCAN_DIV - 1)) begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BLANK: begin
        if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
          w_state_nxt      = S_LOAD;
          w_cnt_nxt        = '0;
          w_idx_nxt        = r_idx + 2'd1;
          w_frame_done_nxt = (r_idx == 2'd3);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Edited pair: hour/month occupy digits 0-1, minute/day digits 2-3.
  always_comb begin
    w_hide_pair = 1'b0;
    if (r_hidden) begin
      case (r_status)
        3'd1, 3'd3: w_hide_pair = ~r_idx[1];
        3'd2, 3'd4: w_hide_pair = r_idx[1];
        default:    w_hide_pair = 1'b0;
      endcase
    end
  end

  assign w_digit = r_idx[0] ? r_rem[3:0] : {1'b0, r_tens};

  always_comb begin
    w_seg      = 7'd0;
    w_dp       = 1'b0;
    w_digit_en = 4'd0;
    if (r_state == S_DRIVE) begin
      w_digit_en = 4'b0001 << r_idx;
      w_seg      = w_hide_pair ? 7'd0 : font(w_digit);
      if (r_idx == 2'd1) begin
        w_dp = (r_status == 3'd0) ? r_second0 : 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_tens       <= 3'd0;
      r_rem        <= 6'd0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_hidden     <= 1'b0;
      r_hour       <= 5'd0;
      r_minute     <= 6'd0;
      r_second0    <= 1'b0;
      r_month      <= 4'd0;
      r_day        <= 5'd0;
      r_status     <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tens       <= w_tens_nxt;
      r_rem        <= w_rem_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_snap) begin
        r_hour    <= bus.hour;
        r_minute  <= bus.minute;
        r_second0 <= bus.second[0];
        r_month   <= bus.month;
        r_day     <= bus.day;
        r_status  <= w_status_live;
      end
      if (r_frame_done) begin
        if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_hidden    <= ~r_hidden;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.seg        = w_seg;
  assign bus.dp         = w_dp;
  assign bus.digit_en   = w_digit_en;
  assign bus.frame_done = r_frame_done;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized bench for clock_display_scan against a frame-level reference model.
module tb_clock_display_scan;
  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_FRAMES = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  clock_display_scan_if bus();

  clock_display_scan #(
    .SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];
  int          len_q[$];
  int          frame_idx = 0;
  int          meas = 0;
  logic [3:0]  last_en = 4'd0;

  logic       n_reset = 1'b1;
  logic [4:0] n_hour = 5'd12;
  logic [5:0] n_minute = 6'd34;
  logic [5:0] n_second = 6'd1;
  logic [3:0] n_month = 4'd1;
  logic [4:0] n_day = 5'd1;
  logic [2:0] n_status = 3'd0;

  logic [6:0] font_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame as a cycle-by-cycle list of {frame_done, dp, digit_en, seg}.
  task automatic build_frame();
    int st, v, tens, dv, len;
    bit cal, hid, hide_pair;
    logic [12:0] e;
    st  = (int'(bus.status) > 4) ? 0 : int'(bus.status);
    cal = (st >= 3);
    hid = ((frame_idx / BLINK_FRAMES) % 2) == 1;
    len = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) v = cal ? int'(bus.month) : int'(bus.hour);
      else       v = cal ? int'(bus.day)   : int'(bus.minute);
      tens = v / 10;
      dv   = (i % 2 == 0) ? tens : (v % 10);
      hide_pair = hid && ((((st == 1) || (st == 3)) && (i < 2)) ||
                          (((st == 2) || (st == 4)) && (i >= 2)));
      for (int c = 0; c < 2 + tens; c++) begin
        e = '0;
        if ((i == 0) && (c == 0) && (frame_idx != 0)) e[12] = 1'b1;
        exp_q.push_back(e);
      end
      for (int c = 0; c < SCAN_DIV; c++) begin
        e = '0;
        e[10:7] = 4'(1 << i);
        e[6:0]  = hide_pair ? 7'd0 : font_tbl[dv];
        if (i == 1) e[11] = (st == 0) ? bus.second[0] : 1'b1;
        exp_q.push_back(e);
      end
      for (int c = 0; c < BLANK_CYCLES; c++) exp_q.push_back(13'd0);
      len += 2 + tens + SCAN_DIV + BLANK_CYCLES;
    end
    len_q.push_back(len);
    frame_idx++;
  endtask

  task automatic step();
    logic prev;
    logic [12:0] e;
    int want_len;
    @(negedge clock);
    prev       = reset;
    reset      = n_reset;
    bus.hour   = n_hour;
    bus.minute = n_minute;
    bus.second = n_second;
    bus.month  = n_month;
    bus.day    = n_day;
    bus.status = n_status;
    if (prev) begin
      exp_q.delete();
      len_q.delete();
      frame_idx = 0;
      meas = 0;
    end else if (bus.frame_done) begin
      want_len = (len_q.size() > 0) ? len_q[0] : -1;
      if (len_q.size() > 0) void'(len_q.pop_front());
      check("frame_len", meas, want_len);
      meas = 0;
    end
    if (exp_q.size() == 0) build_frame();
    e = exp_q.pop_front();
    check("seg", bus.seg, e[6:0]);
    check("digit_en", bus.digit_en, e[10:7]);
    check("dp", bus.dp, e[11]);
    check("frame_done", bus.frame_done, e[12]);
    last_en = e[10:7];
    meas++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_en(input string tag, input logic [3:0] en);
    int k;
    k = 0;
    while ((last_en != en) && (k < 300)) begin
      step();
      k++;
    end
    if (last_en != en) check(tag, last_en, en);
  endtask

  initial begin
    bus.hour = n_hour; bus.minute = n_minute; bus.second = n_second;
    bus.month = n_month; bus.day = n_day; bus.status = n_status;

    run(3);
    n_reset = 1'b0;
    run(4);
    check("first_drive_en", bus.digit_en, 4'b0001);
    run(120);

    n_minute = 6'd59;
    run(200);
    n_minute = 6'd0;
    run(150);

    n_status = 3'd2;
    run(450);

    n_status = 3'd4; n_month = 4'd2; n_day = 5'd29;
    run(100);
    wait_en("wait_digit1", 4'b0010);
    n_day = 5'd30;
    run(160);

    wait_en("wait_digit2", 4'b0100);
    n_reset = 1'b1;
    step();
    n_reset = 1'b0;
    n_hour = 5'd7; n_status = 3'd0;
    step();
    check("reset_mid_en", bus.digit_en, 4'd0);
    check("reset_mid_seg", bus.seg, 7'd0);
    run(150);

    for (int k = 0; k < 3000; k++) begin
      n_reset = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 5))
          0: n_hour   = 5'($urandom);
          1: n_minute = 6'($urandom);
          2: n_second = 6'($urandom);
          3: n_month  = 4'($urandom);
          4: n_day    = 5'($urandom);
          default: n_status = 3'($urandom);
        endcase
      end
      if ($urandom_range(0, 999) == 0) n_reset = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
